// File: rtl/demux_1x8_sched_if.sv
// Handshake and bus bundle between the producer/lane side and the 1x8 demux scheduler.
interface demux_1x8_sched_if #(
  parameter int DATA_W = 1
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic [7:0]        lane_mask;
  logic [7:0]        lane_ready;
  logic [2:0]        sel;
  logic [DATA_W-1:0] out_data;
  logic [7:0]        out_valid;
  logic [15:0]       xfer_count;

  // Handshakes: a word moves on in_* when in_valid & in_ready at a rising edge;
  // the held word moves to lane sel when out_valid[sel] & lane_ready[sel] at a rising edge.
  modport master (
    output in_valid, in_data, lane_mask, lane_ready,
    input  in_ready, sel, out_data, out_valid, xfer_count
  );

  modport slave (
    input  in_valid, in_data, lane_mask, lane_ready,
    output in_ready, sel, out_data, out_valid, xfer_count
  );
endinterface

// File: rtl/demux_1x8_sched.sv
// Round-robin scheduler: grants each incoming word to the next enabled lane and
// holds it on sel/out_data until that lane accepts it.
module demux_1x8_sched #(
  parameter int DATA_W = 1
) (
  input  logic                clk,
  input  logic                rst,
  demux_1x8_sched_if.slave    bus,
  output logic                state_dbg
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [2:0]        ptr_q;
  logic [2:0]        sel_q;
  logic [DATA_W-1:0] data_q;
  logic [7:0]        out_valid_q;
  logic [15:0]       xfer_q;

  logic       accept;
  logic       load;
  logic       ready;
  logic [2:0] grant;

  // Search order starts just after the last grant; ptr itself comes last (k=8 wraps to ptr).
  always_comb begin
    logic       found;
    logic [2:0] idx;
    grant = ptr_q;
    found = 1'b0;
    idx   = ptr_q;
    for (int k = 1; k <= 8; k++) begin
      idx = ptr_q + 3'(k);
      if (!found && bus.lane_mask[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    accept  = (state_q == HOLD) && bus.lane_ready[sel_q];
    ready   = ((state_q == IDLE) || accept) && (bus.lane_mask != 8'h00);
    load    = bus.in_valid && ready;
    state_d = state_q;
    case (state_q)
      IDLE:    if (load) state_d = HOLD;
      HOLD:    if (accept && !load) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= 3'd7;
      sel_q       <= 3'd0;
      data_q      <= '0;
      out_valid_q <= 8'h00;
      xfer_q      <= 16'h0000;
    end else begin
      state_q <= state_d;
      if (load) begin
        data_q      <= bus.in_data;
        sel_q       <= grant;
        ptr_q       <= grant;
        out_valid_q <= 8'h01 << grant;
      end else if (accept) begin
        out_valid_q <= 8'h00;
      end
      if (accept) xfer_q <= xfer_q + 16'd1;
    end
  end

  assign bus.in_ready   = ready;
  assign bus.sel        = sel_q;
  assign bus.out_data   = data_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.xfer_count = xfer_q;
  assign state_dbg      = (state_q == HOLD);

endmodule
